// File: rtl/batch_pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : batch_pixel_fifo
//  Description : Pixel FIFO that accepts a whole batch of BATCH pixels per
//                write and releases one pixel per read. The head pixel is
//                visible on value_out in the same cycle a batch lands.
//  Revision    : 1.0 - initial release
// ============================================================================
module batch_pixel_fifo #(
  parameter int PIXEL_WIDTH  = 12,
  parameter int BATCH        = 8,
  parameter int DEPTH        = 4,
  parameter int ALMOST_EMPTY = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 enqueue,
  input  logic [BATCH*PIXEL_WIDTH-1:0]         value_in,
  input  logic                                 dequeue,
  output logic [PIXEL_WIDTH-1:0]               value_out,
  output logic                                 empty,
  output logic                                 almost_empty,
  output logic                                 full,
  output logic [$clog2(DEPTH*BATCH+1)-1:0]     pixel_count,
  output logic                                 underflow,
  output logic                                 overflow
);

  localparam int c_word_w = BATCH * PIXEL_WIDTH;
  localparam int c_ptr_w  = $clog2(DEPTH);
  localparam int c_idx_w  = $clog2(BATCH);
  localparam int c_cnt_w  = $clog2(DEPTH*BATCH+1);
  localparam int c_slot_w = $clog2(DEPTH+1);

  localparam logic [c_cnt_w-1:0]  c_batch_cnt   = c_cnt_w'(BATCH);
  localparam logic [c_idx_w-1:0]  c_last_idx    = c_idx_w'(BATCH-1);
  localparam logic [c_slot_w-1:0] c_depth_slots = c_slot_w'(DEPTH);

  // Batch storage; contents are never cleared, only pointers are.
  logic [c_word_w-1:0] mem_q [DEPTH];

  logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_idx_w-1:0]  pix_idx_q, pix_idx_d;
  logic [c_cnt_w-1:0]  count_q, count_d;
  // Slots holding any unread pixel, including a partially read head batch.
  logic [c_slot_w-1:0] slots_q, slots_d;
  logic                underflow_q, underflow_d;
  logic                overflow_q, overflow_d;

  logic                enq_ok;
  logic                deq_ok;
  logic                deq_last;
  logic                mem_we;

  logic [c_word_w-1:0]    head_word;
  logic [PIXEL_WIDTH-1:0] head_pix [BATCH];

  // Status flags come straight from registered state, no same-cycle bypass.
  always_comb begin
    empty        = (count_q == '0);
    almost_empty = (int'(count_q) <= ALMOST_EMPTY);
    full         = (slots_q == c_depth_slots);
    pixel_count  = count_q;
    underflow    = underflow_q;
    overflow     = overflow_q;
  end

  // Accept decisions: requests are judged against start-of-cycle flags only.
  always_comb begin
    enq_ok   = enqueue & ~full;
    deq_ok   = dequeue & ~empty;
    deq_last = deq_ok & (pix_idx_q == c_last_idx);
    mem_we   = enq_ok & ~flush & ~reset;
  end

  // Split the head word into pixels; pixel 0 is the most significant slice.
  assign head_word = mem_q[rd_ptr_q];
  for (genvar gi = 0; gi < BATCH; gi++) begin : g_unpack
    assign head_pix[gi] = head_word[(BATCH-1-gi)*PIXEL_WIDTH +: PIXEL_WIDTH];
  end

  // Head pixel is combinational from storage so a new batch shows at once.
  always_comb begin
    value_out = empty ? '0 : head_pix[pix_idx_q];
  end

  // Next-state computation; flush overrides both request paths.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pix_idx_d   = pix_idx_q;
    count_d     = count_q;
    slots_d     = slots_q;
    underflow_d = underflow_q;
    overflow_d  = overflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      pix_idx_d   = '0;
      count_d     = '0;
      slots_d     = '0;
      underflow_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      if (enq_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (deq_ok) begin
        if (deq_last) begin
          pix_idx_d = '0;
          rd_ptr_d  = rd_ptr_q + 1'b1;
        end else begin
          pix_idx_d = pix_idx_q + 1'b1;
        end
      end
      count_d     = count_q + (enq_ok ? c_batch_cnt : '0) - c_cnt_w'(deq_ok);
      slots_d     = slots_q + c_slot_w'(enq_ok) - c_slot_w'(deq_last);
      underflow_d = underflow_q | (dequeue & empty);
      overflow_d  = overflow_q | (enqueue & full);
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pix_idx_q   <= '0;
      count_q     <= '0;
      slots_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pix_idx_q   <= pix_idx_d;
      count_q     <= count_d;
      slots_q     <= slots_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  // Batch write port; storage has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= value_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_batch_pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_batch_pixel_fifo
//  Description : Self-checking bench for batch_pixel_fifo (default params).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_batch_pixel_fifo;

  localparam int PW = 12;
  localparam int B  = 8;
  localparam int D  = 4;
  localparam int AE = 8;
  localparam int CW = $clog2(D*B+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          enqueue;
  logic          dequeue;
  logic [B*PW-1:0] value_in;
  logic [PW-1:0] value_out;
  logic          empty;
  logic          almost_empty;
  logic          full;
  logic [CW-1:0] pixel_count;
  logic          underflow;
  logic          overflow;

  batch_pixel_fifo #(
    .PIXEL_WIDTH (PW),
    .BATCH       (B),
    .DEPTH       (D),
    .ALMOST_EMPTY(AE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .enqueue     (enqueue),
    .value_in    (value_in),
    .dequeue     (dequeue),
    .value_out   (value_out),
    .empty       (empty),
    .almost_empty(almost_empty),
    .full        (full),
    .pixel_count (pixel_count),
    .underflow   (underflow),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the FIFO is just an ordered list of pixels plus two flags.
  logic [PW-1:0] mq[$];
  bit            m_uf;
  bit            m_of;

  typedef struct {
    int f;   int e;   int d;   int base;
    int cnt; int vo;  int emp; int ae;
    int fl;  int uf;  int of;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [B*PW-1:0] make_batch(input int base);
    logic [B*PW-1:0] w;
    w = '0;
    for (int i = 0; i < B; i++) w[(B-1-i)*PW +: PW] = PW'(base + i);
    return w;
  endfunction

  function automatic bit model_full();
    return ((mq.size() + B - 1) / B) >= D;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit f, input bit e, input logic [B*PW-1:0] v, input bit d);
    bit was_empty;
    bit was_full;
    was_empty = (mq.size() == 0);
    was_full  = model_full();
    if (f) begin
      mq.delete();
      m_uf = 1'b0;
      m_of = 1'b0;
    end else begin
      if (d) begin
        if (was_empty) m_uf = 1'b1;
        else void'(mq.pop_front());
      end
      if (e) begin
        if (was_full) m_of = 1'b1;
        else for (int i = 0; i < B; i++) mq.push_back(v[(B-1-i)*PW +: PW]);
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [PW-1:0] exp_vo;
    exp_vo = (mq.size() != 0) ? mq[0] : '0;
    chk({tag, " count"},     64'(pixel_count),  64'(mq.size()));
    chk({tag, " value_out"}, 64'(value_out),    64'(exp_vo));
    chk({tag, " empty"},     64'(empty),        64'(mq.size() == 0));
    chk({tag, " almost"},    64'(almost_empty), 64'(mq.size() <= AE));
    chk({tag, " full"},      64'(full),         64'(model_full()));
    chk({tag, " underflow"}, 64'(underflow),    64'(m_uf));
    chk({tag, " overflow"},  64'(overflow),     64'(m_of));
  endtask

  // One clock: drive inputs, let the edge happen, update model, sample #1 later.
  task automatic step(input bit f, input bit e, input logic [B*PW-1:0] v,
                      input bit d, input bit do_check, input string tag);
    flush    = f;
    enqueue  = e;
    value_in = v;
    dequeue  = d;
    @(posedge clk);
    model_step(f, e, v, d);
    #1;
    if (do_check) check_model(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int nxt;
    int eps[4];
    int dps[4];
    eps = '{70, 20, 45, 55};
    dps = '{30, 80, 50, 50};

    // Table: one batch in, eight pixels out, then the empty corners.
    tbl[0] = '{0, 1, 0, 0, 8, 0, 0, 1, 0, 0, 0};
    for (int k = 1; k <= 8; k++)
      tbl[k] = '{0, 0, 1, 0, 8-k, (k < 8) ? k : 0, (k == 8) ? 1 : 0, 1, 0, 0, 0};
    tbl[9]  = '{0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[11] = '{0, 1, 1, 16, 8, 16, 0, 1, 0, 1, 0};

    reset = 1'b1; flush = 1'b0; enqueue = 1'b0; dequeue = 1'b0; value_in = '0;
    m_uf = 1'b0; m_of = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset empty",     64'(empty), 64'd1);
    chk("reset almost",    64'(almost_empty), 64'd1);
    chk("reset full",      64'(full), 64'd0);
    chk("reset value_out", 64'(value_out), 64'd0);
    chk("reset count",     64'(pixel_count), 64'd0);
    chk("reset flags",     64'({underflow, overflow}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(bit'(tbl[i].f), bit'(tbl[i].e), make_batch(tbl[i].base), bit'(tbl[i].d), 1'b0, "tbl");
      chk($sformatf("tbl%0d count", i),     64'(pixel_count),  64'(tbl[i].cnt));
      chk($sformatf("tbl%0d value_out", i), 64'(value_out),    64'(tbl[i].vo));
      chk($sformatf("tbl%0d empty", i),     64'(empty),        64'(tbl[i].emp));
      chk($sformatf("tbl%0d almost", i),    64'(almost_empty), 64'(tbl[i].ae));
      chk($sformatf("tbl%0d full", i),      64'(full),         64'(tbl[i].fl));
      chk($sformatf("tbl%0d underflow", i), 64'(underflow),    64'(tbl[i].uf));
      chk($sformatf("tbl%0d overflow", i),  64'(overflow),     64'(tbl[i].of));
    end

    // Fill to full, reject a fifth batch, then read everything back.
    step(1, 0, '0, 0, 1, "fill flush");
    for (int b = 0; b < D; b++) step(0, 1, make_batch(256*(b+1)), 0, 1, "fill");
    chk("fill full",   64'(full), 64'd1);
    chk("fill count",  64'(pixel_count), 64'd32);
    chk("fill almost", 64'(almost_empty), 64'd0);
    step(0, 1, make_batch(12'hF00), 0, 1, "fill extra");
    chk("fill overflow", 64'(overflow), 64'd1);
    chk("fill count2",   64'(pixel_count), 64'd32);
    for (int k = 0; k < D*B; k++) begin
      chk("fill readback", 64'(value_out), 64'(256*(k/B+1) + k%B));
      step(0, 0, '0, 1, 1, "fill drain");
    end
    chk("fill drained empty", 64'(empty), 64'd1);

    // Head holds its last pixel (index 7); enqueue+dequeue together.
    step(1, 0, '0, 0, 1, "sim flush");
    step(0, 1, make_batch(12'h500), 0, 1, "sim enq");
    for (int k = 0; k < B-1; k++) step(0, 0, '0, 1, 1, "sim deq");
    chk("sim count1", 64'(pixel_count), 64'd1);
    step(0, 1, make_batch(12'h600), 1, 1, "sim both");
    chk("sim count", 64'(pixel_count), 64'(1 + B - 1));
    chk("sim value", 64'(value_out), 64'h600);
    step(0, 0, '0, 1, 1, "sim next");
    chk("sim next value", 64'(value_out), 64'h601);

    // Flush with enqueue at count=20, then asynchronous reset mid-cycle.
    step(1, 0, '0, 0, 1, "fl flush");
    step(0, 0, '0, 1, 1, "fl uf");
    for (int b = 0; b < 3; b++) step(0, 1, make_batch(12'h700 + 256*b), 0, 1, "fl enq");
    for (int k = 0; k < 4; k++) step(0, 0, '0, 1, 1, "fl deq");
    chk("fl count20", 64'(pixel_count), 64'd20);
    step(1, 1, make_batch(12'hA00), 0, 1, "fl both");
    chk("fl count0", 64'(pixel_count), 64'd0);
    chk("fl flags",  64'({underflow, overflow}), 64'd0);
    step(0, 1, make_batch(12'hB00), 0, 1, "fl refill");
    enqueue = 1'b1; value_in = make_batch(12'hD00);
    #3;
    reset = 1'b1;
    #1;
    chk("async empty",  64'(empty), 64'd1);
    chk("async almost", 64'(almost_empty), 64'd1);
    chk("async full",   64'(full), 64'd0);
    chk("async value",  64'(value_out), 64'd0);
    chk("async count",  64'(pixel_count), 64'd0);
    mq.delete(); m_uf = 1'b0; m_of = 1'b0;
    @(posedge clk);
    #1;
    chk("reset held count", 64'(pixel_count), 64'd0);
    reset = 1'b0;
    enqueue = 1'b0;
    step(0, 1, make_batch(12'hC00), 0, 1, "post reset");
    chk("post reset value", 64'(value_out), 64'hC00);

    // Streaming across several pointer wraps.
    step(1, 0, '0, 0, 1, "wr flush");
    step(0, 1, make_batch(0), 0, 1, "wr first");
    nb = 1;
    nxt = 0;
    for (int c = 0; c < 300; c++) begin
      bit e;
      if (nb == 3*D && mq.size() == 0) break;
      e = (mq.size() <= AE) && !model_full() && (nb < 3*D);
      if (mq.size() != 0) begin
        chk("stream order", 64'(value_out), 64'(PW'(nxt)));
        nxt++;
      end
      step(0, e, e ? make_batch(nb*B) : '0, mq.size() != 0, 1, "stream");
      if (e) nb++;
    end
    chk("stream total", 64'(nxt), 64'(3*D*B));
    chk("stream underflow", 64'(underflow), 64'd0);

    // Randomised traffic against the model.
    step(1, 0, '0, 0, 1, "rnd flush");
    for (int c = 0; c < 600; c++) begin
      int ph;
      ph = c / 150;
      step($urandom_range(0, 79) == 0,
           $urandom_range(0, 99) < eps[ph],
           {$urandom(), $urandom(), $urandom()},
           $urandom_range(0, 99) < dps[ph], 1, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
